// File: rtl/hello_pkg.sv
// Shared encodings for the HELLO FTYPE router and its TDEST demultiplexer.
package hello_pkg;

  // TDEST route codes; any code with bit 1 set is unroutable and is dropped.
  localparam logic [1:0] ROUTE_M0   = 2'd0;
  localparam logic [1:0] ROUTE_M1   = 2'd1;
  localparam logic [1:0] ROUTE_DROP = 2'd2;

  // SWRITE transactions are the ones the router steers to port 1.
  localparam logic [3:0] FTYPE_SWRITE = 4'h6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD0 = 2'd1,
    FWD1 = 2'd2,
    DROP = 2'd3
  } state_t;

  // Routes 2 and 3 have no master port behind them.
  function automatic logic is_drop_route(input logic [1:0] dest);
    return dest[1];
  endfunction

endpackage

// File: rtl/hello_axis_reg.sv
// One-entry AXIS output register. It can be reloaded in the same cycle it
// drains, so back-to-back beats flow at full rate. TVALID comes straight from
// a flop and never depends on TREADY.
module hello_axis_reg #(
  parameter int DATA_W = 64,
  parameter int USER_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic [USER_W-1:0] user_i,
  input  logic              ready_i,
  output logic              accept_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic [USER_W-1:0] user_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              last_q,  last_d;
  logic [USER_W-1:0] user_q,  user_d;

  // Space is available when empty or when the held beat leaves this cycle.
  assign accept_o = ~valid_q | ready_i;

  // Next state: a load wins over a drain, leaving the new beat valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    user_d  = user_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
      user_d  = user_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Register; reset empties the entry and clears the payload.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign user_o  = user_q;

endmodule

// File: rtl/hello_tdest_demux.sv
// Whole-packet TDEST demultiplexer behind the HELLO FTYPE router: route 0 to
// M0, route 1 (SWRITE) to M1, routes 2/3 are swallowed. The header beat picks
// the route and it stays locked until TLAST. Saturating status counters track
// completed packets per port and dropped packets.
module hello_tdest_demux
  import hello_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int USER_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  input  logic [1:0]        S_AXIS_TDEST,
  input  logic [USER_W-1:0] S_AXIS_TUSER,
  output logic              M0_AXIS_TVALID,
  input  logic              M0_AXIS_TREADY,
  output logic [DATA_W-1:0] M0_AXIS_TDATA,
  output logic              M0_AXIS_TLAST,
  output logic [USER_W-1:0] M0_AXIS_TUSER,
  output logic              M1_AXIS_TVALID,
  input  logic              M1_AXIS_TREADY,
  output logic [DATA_W-1:0] M1_AXIS_TDATA,
  output logic              M1_AXIS_TLAST,
  output logic [USER_W-1:0] M1_AXIS_TUSER,
  input  logic              clear_counters,
  output logic [CNT_W-1:0]  pkt0_count,
  output logic [CNT_W-1:0]  pkt1_count,
  output logic [CNT_W-1:0]  drop_count
);

  state_t     state_q, state_d;
  logic [1:0] route_sel;
  logic       s_ready;
  logic       s_xfr;
  logic       acc0, acc1;
  logic       load0, load1;
  logic [2:0] cnt_inc;

  // Route selection, slave ready and packet-framing state machine.
  always_comb begin
    state_d   = state_q;
    route_sel = ROUTE_M0;
    s_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        route_sel = S_AXIS_TDEST;
        if (is_drop_route(S_AXIS_TDEST)) s_ready = 1'b1;
        else if (S_AXIS_TDEST == ROUTE_M0) s_ready = acc0;
        else s_ready = acc1;
      end
      FWD0: begin
        route_sel = ROUTE_M0;
        s_ready   = acc0;
      end
      FWD1: begin
        route_sel = ROUTE_M1;
        s_ready   = acc1;
      end
      DROP: begin
        route_sel = ROUTE_DROP;
        s_ready   = 1'b1;
      end
      default: ;
    endcase
    // Nothing is accepted while reset is held, even though both registers are empty.
    s_ready = s_ready & AXIS_ARESETN;
    s_xfr   = S_AXIS_TVALID & s_ready;
    if (s_xfr) begin
      if (S_AXIS_TLAST) begin
        state_d = IDLE;
      end else if (state_q == IDLE) begin
        if (is_drop_route(route_sel)) state_d = DROP;
        else if (route_sel == ROUTE_M0) state_d = FWD0;
        else state_d = FWD1;
      end
    end
  end

  // State register; reset truncates any packet in flight.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) state_q <= IDLE;
    else               state_q <= state_d;
  end

  assign S_AXIS_TREADY = s_ready;
  assign load0 = s_xfr & (route_sel == ROUTE_M0);
  assign load1 = s_xfr & (route_sel == ROUTE_M1);

  hello_axis_reg #(.DATA_W(DATA_W), .USER_W(USER_W)) u_reg_m0 (
    .clk_i    (AXIS_ACLK),
    .rst_ni   (AXIS_ARESETN),
    .load_i   (load0),
    .data_i   (S_AXIS_TDATA),
    .last_i   (S_AXIS_TLAST),
    .user_i   (S_AXIS_TUSER),
    .ready_i  (M0_AXIS_TREADY),
    .accept_o (acc0),
    .valid_o  (M0_AXIS_TVALID),
    .data_o   (M0_AXIS_TDATA),
    .last_o   (M0_AXIS_TLAST),
    .user_o   (M0_AXIS_TUSER)
  );

  hello_axis_reg #(.DATA_W(DATA_W), .USER_W(USER_W)) u_reg_m1 (
    .clk_i    (AXIS_ACLK),
    .rst_ni   (AXIS_ARESETN),
    .load_i   (load1),
    .data_i   (S_AXIS_TDATA),
    .last_i   (S_AXIS_TLAST),
    .user_i   (S_AXIS_TUSER),
    .ready_i  (M1_AXIS_TREADY),
    .accept_o (acc1),
    .valid_o  (M1_AXIS_TVALID),
    .data_o   (M1_AXIS_TDATA),
    .last_o   (M1_AXIS_TLAST),
    .user_o   (M1_AXIS_TUSER)
  );

  // Packet completions: master-side TLAST transfers, or a TLAST beat swallowed by the drop route.
  assign cnt_inc[0] = M0_AXIS_TVALID & M0_AXIS_TREADY & M0_AXIS_TLAST;
  assign cnt_inc[1] = M1_AXIS_TVALID & M1_AXIS_TREADY & M1_AXIS_TLAST;
  assign cnt_inc[2] = s_xfr & S_AXIS_TLAST & is_drop_route(route_sel);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Saturating increment; clear takes priority over a same-cycle increment.
      always_comb begin
        cnt_d = cnt_q;
        if (clear_counters) cnt_d = '0;
        else if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
      end

      // Counter register.
      always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) cnt_q <= '0;
        else               cnt_q <= cnt_d;
      end
    end
  endgenerate

  assign pkt0_count = g_cnt[0].cnt_q;
  assign pkt1_count = g_cnt[1].cnt_q;
  assign drop_count = g_cnt[2].cnt_q;

endmodule

// File: tb/tb_hello_tdest_demux.sv
// Directed bench for hello_tdest_demux with a per-port scoreboard: expected
// beats are queued when the slave accepts them and popped by a monitor when
// each master port transfers.
module tb_hello_tdest_demux;

  localparam int DATA_W = 64;
  localparam int USER_W = 32;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [USER_W-1:0] user;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_tvalid, s_tready, s_tlast;
  logic [DATA_W-1:0] s_tdata;
  logic [1:0]        s_tdest;
  logic [USER_W-1:0] s_tuser;
  logic              m0_tvalid, m0_tready, m0_tlast;
  logic [DATA_W-1:0] m0_tdata;
  logic [USER_W-1:0] m0_tuser;
  logic              m1_tvalid, m1_tready, m1_tlast;
  logic [DATA_W-1:0] m1_tdata;
  logic [USER_W-1:0] m1_tuser;
  logic              clear;
  logic [CNT_W-1:0]  pkt0, pkt1, drops;

  beat_t      q0[$];
  beat_t      q1[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         tb_in_pkt = 1'b0;
  logic [1:0] tb_route  = 2'd0;

  always #5 clk = ~clk;

  hello_tdest_demux #(.DATA_W(DATA_W), .USER_W(USER_W), .CNT_W(CNT_W)) dut (
    .AXIS_ACLK      (clk),
    .AXIS_ARESETN   (rst_n),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TREADY  (s_tready),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TDEST   (s_tdest),
    .S_AXIS_TUSER   (s_tuser),
    .M0_AXIS_TVALID (m0_tvalid),
    .M0_AXIS_TREADY (m0_tready),
    .M0_AXIS_TDATA  (m0_tdata),
    .M0_AXIS_TLAST  (m0_tlast),
    .M0_AXIS_TUSER  (m0_tuser),
    .M1_AXIS_TVALID (m1_tvalid),
    .M1_AXIS_TREADY (m1_tready),
    .M1_AXIS_TDATA  (m1_tdata),
    .M1_AXIS_TLAST  (m1_tlast),
    .M1_AXIS_TUSER  (m1_tuser),
    .clear_counters (clear),
    .pkt0_count     (pkt0),
    .pkt1_count     (pkt1),
    .drop_count     (drops)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every master transfer must match the head of its port queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n === 1'b1) begin
      if (m0_tvalid && m0_tready) begin
        if (q0.size() == 0) check("m0_unexpected_valid", m0_tvalid, 0);
        else begin
          e = q0.pop_front();
          check("m0_beat", {m0_tdata, m0_tlast, m0_tuser}, e);
          $display("M0 beat data=%h last=%0d user=%h", m0_tdata, m0_tlast, m0_tuser);
        end
      end
      if (m1_tvalid && m1_tready) begin
        if (q1.size() == 0) check("m1_unexpected_valid", m1_tvalid, 0);
        else begin
          e = q1.pop_front();
          check("m1_beat", {m1_tdata, m1_tlast, m1_tuser}, e);
          $display("M1 beat data=%h last=%0d user=%h", m1_tdata, m1_tlast, m1_tuser);
        end
      end
    end
  end

  // Drive one beat (called at posedge+1) and wait, bounded, for the slave transfer.
  task automatic send(input logic [1:0] dest, input logic last);
    logic [1:0] r;
    int         w;
    beat_t      b;
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, $urandom};
    s_tlast  = last;
    s_tdest  = dest;
    s_tuser  = $urandom;
    r = tb_in_pkt ? tb_route : dest;
    w = 0;
    @(negedge clk);
    while (s_tready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (s_tready !== 1'b1) begin
      check("s_ready_timeout", s_tready, 1);
      s_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    b = '{data: s_tdata, last: last, user: s_tuser};
    if (r == 2'd0) q0.push_back(b);
    else if (r == 2'd1) q1.push_back(b);
    tb_in_pkt = !last;
    tb_route  = r;
    s_tvalid  = 1'b0;
  endtask

  // Wait, bounded, until every queued beat has left the DUT, then let counters settle.
  task automatic wait_drain();
    int w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (q0.size() != 0 || q1.size() != 0) check("drain_timeout", q0.size() + q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tdest = 2'd0;
    s_tuser = '0; m0_tready = 1'b1; m1_tready = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_sready", s_tready, 0);
    check("rst_m0_valid", m0_tvalid, 0);
    check("rst_m1_valid", m1_tvalid, 0);
    check("rst_m0_data", m0_tdata, 0);
    check("rst_counts", {pkt0, pkt1, drops}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3-beat packet to M0, one-cycle latency
    send(2'd0, 1'b0);
    check("t1_latency_m0_valid", m0_tvalid, 1);
    send(2'd0, 1'b0);
    send(2'd0, 1'b1);
    wait_drain();
    check("t1_pkt0", pkt0, 1);
    check("t1_pkt1", pkt1, 0);

    // Route locked by header despite TDEST=0 on beat 2
    send(2'd1, 1'b0);
    send(2'd0, 1'b1);
    wait_drain();
    check("t2_pkt1", pkt1, 1);
    check("t2_pkt0", pkt0, 1);

    // Single-beat TDEST=3 dropped, following M0 packet unaffected
    s_tvalid = 1'b1; s_tdest = 2'd3; s_tlast = 1'b1;
    #1;
    check("t3_drop_sready", s_tready, 1);
    send(2'd3, 1'b1);
    check("t3_no_m0_valid", m0_tvalid, 0);
    check("t3_no_m1_valid", m1_tvalid, 0);
    send(2'd0, 1'b1);
    wait_drain();
    check("t3_drop", drops, 1);
    check("t3_pkt0", pkt0, 2);

    // M1 stalled: second beat and the next M0 packet must wait
    m1_tready = 1'b0;
    send(2'd1, 1'b0);
    s_tvalid = 1'b1; s_tdest = 2'd1; s_tlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_sready", s_tready, 0);
      check("t4_m1_held", m1_tvalid, 1);
      check("t4_m0_idle", m0_tvalid, 0);
    end
    @(posedge clk);
    #1;
    m1_tready = 1'b1;
    send(2'd1, 1'b1);
    send(2'd0, 1'b1);
    wait_drain();
    check("t4_pkt1", pkt1, 2);
    check("t4_pkt0", pkt0, 3);

    // Clear, then saturate pkt0
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("t5_cleared", {pkt0, pkt1, drops}, 0);
    for (int i = 0; i < 65540; i++) send(2'd0, 1'b1);
    wait_drain();
    check("t5_pkt0_saturated", pkt0, 16'hFFFF);
    // Clear coincides with the M0 TLAST transfer
    send(2'd0, 1'b1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("t5_clear_vs_pkt0_inc", pkt0, 0);
    send(2'd2, 1'b1);
    @(posedge clk);
    #1;
    check("t5_drop_one", drops, 1);
    // Clear coincides with a dropped TLAST
    clear = 1'b1;
    send(2'd3, 1'b1);
    clear = 1'b0;
    check("t5_clear_vs_drop_inc", drops, 0);
    wait_drain();

    // Reset in the middle of a 4-beat M0 packet
    send(2'd0, 1'b0);
    send(2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_m0_valid_drops", m0_tvalid, 0);
    check("t6_sready_in_reset", s_tready, 0);
    check("t6_counts_reset", {pkt0, pkt1, drops}, 0);
    q0.delete();
    tb_in_pkt = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'd1, 1'b1);
    check("t6_m1_last", m1_tlast, 1);
    wait_drain();
    check("t6_pkt1", pkt1, 1);
    check("t6_pkt0", pkt0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
